disp_arbiter: RTL and testbench
===============================

# disp_arbiter

Sequencer/arbiter that shares the single 8-digit seven-segment display between four 32-bit data sources and one priority channel. It sits directly upstream of `display`, driving its `data_to_show` bus, and decides which source is visible, for how long, and when a priority message (e.g. a syscall print) preempts the rotation.

## Interface
- `DWELL`, 50_000_000: cycles each source stays visible in auto-cycle mode (≥2).
- `HOLD`, 25_000_000: minimum cycles a priority value stays visible (≥2).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `src_req`  in  4  source i requests display time (level).
- `src_data`  in  128  source i value at bits [32i+31:32i].
- `sel_btn`  in  1  manual advance; synchronous level, rising edge detected internally.
- `pri_req`  in  1  priority display request (level).
- `pri_data`  in  32  priority value, sampled on capture.
- `pri_ack`  out  1  one-cycle pulse per priority capture.
- `src_gnt`  out  4  one-hot index of visible source; 0 when none.
- `data_to_show`  out  32  value for the display module.
- `blank`  out  1  high when nothing is shown.

## Operation
- States: IDLE, SHOW, PRI_HOLD. Registers: `cur` (2b), `cnt` (32b), `pri_lat` (32b), `btn_d`.
- Next-source search: first index with `src_req` set, scanning cyclically from `cur+1` through `cur`. The current source is re-chosen only if it is the sole requester.
- IDLE: `blank`=1, `src_gnt`=0, `data_to_show`=0.
  - `pri_req` → capture and go to PRI_HOLD.
  - Otherwise any `src_req` → search from `cur+1` and go to SHOW.
- SHOW: `data_to_show` ← `src_data[cur]` every cycle (live tracking). `src_gnt` = 1<<cur. `blank`=0.
  - Advance triggers: `sel_btn` rising edge, or `cnt`==DWELL-1 (auto-cycle), or `src_req[cur]` low.
  - On advance: if no requester, go to IDLE. Otherwise run the search. `cnt` clears on every advance.
- Capture: `pri_lat` ← `pri_data`, pulse `pri_ack`, clear `cnt`, enter or stay in PRI_HOLD.
- PRI_HOLD: `data_to_show`=`pri_lat`, `src_gnt`=0, `blank`=0. `sel_btn` edges are ignored (edge detector still updates).
  - At `cnt`==HOLD-1 with `pri_req` high: capture again.
  - At `cnt`==HOLD-1 with `pri_req` low: go to SHOW with `cur` if `src_req[cur]`. Otherwise search, or go to IDLE if no requester.
- `pri_req` in IDLE or SHOW has priority over every source event in the same cycle.
- `cur` is retained across PRI_HOLD and IDLE.

## Timing
- All outputs are registered. Every response lands one cycle after its triggering input cycle.
- Reset values: state IDLE, `cur`=0, `cnt`=0, `pri_lat`=0, `btn_d`=0, `data_to_show`=0, `blank`=1, `src_gnt`=0, `pri_ack`=0.
- Dwell: a source stays exactly DWELL cycles in SHOW absent other triggers.
- Priority hold: exactly HOLD cycles per capture. `pri_ack` is high in the first of them.
- Simultaneous button edge, dwell expiry and request drop produce a single advance.
- `rst` mid-hold or mid-dwell: immediately returns all registers to reset values. The pending priority value is discarded, with no ack.
- `src_data` changes are visible one cycle later. `pri_data` changes after capture are not visible.

## Configuration
- `DISP_ARB_AUTO_CYCLE_EN` defined: dwell expiry is an advance trigger, as described above.
- `DISP_ARB_AUTO_CYCLE_EN` undefined: SHOW advances only on a button edge or a request drop.
  - `cnt` is used only in PRI_HOLD.
  - `DWELL` is ignored.
  - A source stays visible indefinitely.

## Test plan
(DWELL=4, HOLD=3, auto-cycle enabled unless stated.)
1. Reset, then `src_req`=4'b0101, src0=0x11111111, src2=0x22222222.
   - Response: `src_gnt` 0001 with 0x11111111 for 4 cycles, then 0100 with 0x22222222 for 4 cycles, then back to 0001.
2. Only src1 requesting, one `sel_btn` pulse.
   - Response: `src_gnt` stays 0010 and `cnt` restarts (next change comes 4 cycles after the press).
3. In SHOW src0, raise `pri_req` with `pri_data`=0xDEADBEEF for 1 cycle.
   - Response: `pri_ack` pulses once, 0xDEADBEEF is shown for 3 cycles with `src_gnt`=0, then src0 resumes.
4. Hold `pri_req` high for 8 cycles with `pri_data` incrementing.
   - Response: three captures 3 cycles apart, each shown value equal to `pri_data` at its capture cycle.
5. Drop all `src_req` during SHOW; separately, assert `rst` mid-PRI_HOLD.
   - Response: IDLE with `blank`=1 and `data_to_show`=0 next cycle. The `rst` case gives all outputs at their reset values.
6. Build without `DISP_ARB_AUTO_CYCLE_EN`, `src_req`=4'b1111, 20 idle cycles.
   - Response: `src_gnt` stays 0001.
   - Each subsequent `sel_btn` edge steps 0010 → 0100 → 1000 → 0001.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares one 8-digit display between four sources and a priority channel.
// Define DISP_ARB_AUTO_CYCLE_EN to make SHOW rotate to the next source every DWELL cycles.
module disp_arbiter #(
    parameter int DWELL = 50_000_000,
    parameter int HOLD  = 25_000_000
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [3:0]   i_src_req,
    input  logic [127:0] i_src_data,
    input  logic         i_sel_btn,
    input  logic         i_pri_req,
    input  logic [31:0]  i_pri_data,
    output logic         o_pri_ack,
    output logic [3:0]   o_src_gnt,
    output logic [31:0]  o_data_to_show,
    output logic         o_blank
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SHOW     = 2'd1;
    localparam logic [1:0] S_PRI_HOLD = 2'd2;

`ifdef DISP_ARB_AUTO_CYCLE_EN
    localparam logic AUTO_CYCLE = 1'b1;
`else
    localparam logic AUTO_CYCLE = 1'b0;
`endif

    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_cur;
    logic [31:0] r_cnt;
    logic [31:0] r_pri_lat;
    logic        r_btn_d;
    logic        r_pri_ack;
    logic [3:0]  r_src_gnt;
    logic [31:0] r_data;
    logic        r_blank;

    logic [1:0]  w_state_n;
    logic [1:0]  w_cur_n;
    logic [31:0] w_cnt_n;
    logic [31:0] w_pri_lat_n;
    logic        w_ack_n;
    logic        w_capture;
    logic        w_btn_rise;
    logic        w_any_req;
    logic        w_dwell_done;
    logic        w_hold_done;
    logic        w_advance;
    logic [1:0]  w_search;

    // Cyclic scan starting after cur; cur itself is the last candidate.
    function automatic logic [1:0] next_src(input logic [1:0] cur, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign w_btn_rise   = i_sel_btn & ~r_btn_d;
    assign w_any_req    = |i_src_req;
    assign w_search     = next_src(r_cur, i_src_req);
    assign w_dwell_done = AUTO_CYCLE & (r_cnt == DWELL_LAST);
    assign w_hold_done  = (r_cnt == HOLD_LAST);
    assign w_advance    = w_btn_rise | w_dwell_done | ~i_src_req[r_cur];

    always_comb begin
        w_state_n   = r_state;
        w_cur_n     = r_cur;
        w_cnt_n     = r_cnt;
        w_pri_lat_n = r_pri_lat;
        w_ack_n     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (i_pri_req) begin
                    w_capture = 1'b1;
                end else if (w_any_req) begin
                    w_state_n = S_SHOW;
                    w_cur_n   = w_search;
                end
            end
            S_SHOW: begin
                if (i_pri_req) begin
                    w_capture = 1'b1;
                end else if (w_advance) begin
                    w_cnt_n = '0;
                    if (!w_any_req) w_state_n = S_IDLE;
                    else            w_cur_n   = w_search;
                end else begin
                    w_cnt_n = AUTO_CYCLE ? r_cnt + 32'd1 : '0;
                end
            end
            S_PRI_HOLD: begin
                if (!w_hold_done) begin
                    w_cnt_n = r_cnt + 32'd1;
                end else if (i_pri_req) begin
                    w_capture = 1'b1;
                end else begin
                    w_cnt_n = '0;
                    if (i_src_req[r_cur]) begin
                        w_state_n = S_SHOW;
                    end else if (w_any_req) begin
                        w_state_n = S_SHOW;
                        w_cur_n   = w_search;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
        if (w_capture) begin
            w_state_n   = S_PRI_HOLD;
            w_pri_lat_n = i_pri_data;
            w_ack_n     = 1'b1;
            w_cnt_n     = '0;
        end
    end

    // Outputs are derived from the next state so each response appears one cycle after its cause.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cur     <= 2'd0;
            r_cnt     <= '0;
            r_pri_lat <= '0;
            r_btn_d   <= 1'b0;
            r_pri_ack <= 1'b0;
            r_src_gnt <= 4'b0000;
            r_data    <= '0;
            r_blank   <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_cur     <= w_cur_n;
            r_cnt     <= w_cnt_n;
            r_pri_lat <= w_pri_lat_n;
            r_btn_d   <= i_sel_btn;
            r_pri_ack <= w_ack_n;
            r_src_gnt <= (w_state_n == S_SHOW) ? (4'b0001 << w_cur_n) : 4'b0000;
            r_blank   <= (w_state_n == S_IDLE);
            case (w_state_n)
                S_SHOW:     r_data <= i_src_data[{w_cur_n, 5'b00000} +: 32];
                S_PRI_HOLD: r_data <= w_pri_lat_n;
                default:    r_data <= '0;
            endcase
        end
    end

    assign o_pri_ack      = r_pri_ack;
    assign o_src_gnt      = r_src_gnt;
    assign o_data_to_show = r_data;
    assign o_blank        = r_blank;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter with DWELL=4, HOLD=3.
// Auto-cycle scenarios run when DISP_ARB_AUTO_CYCLE_EN is defined, manual stepping otherwise.
module tb_disp_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   srcReq = 4'b0000;
    logic [127:0] srcData = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    logic         selBtn = 1'b0;
    logic         priReq = 1'b0;
    logic [31:0]  priData = 32'h0;
    logic         priAck;
    logic [3:0]   srcGnt;
    logic [31:0]  dataToShow;
    logic         blank;

    int passCount = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    disp_arbiter #(.DWELL(4), .HOLD(3)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_src_req      (srcReq),
        .i_src_data     (srcData),
        .i_sel_btn      (selBtn),
        .i_pri_req      (priReq),
        .i_pri_data     (priData),
        .o_pri_ack      (priAck),
        .o_src_gnt      (srcGnt),
        .o_data_to_show (dataToShow),
        .o_blank        (blank)
    );

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        srcReq = 4'b0000;
        selBtn = 1'b0;
        priReq = 1'b0;
        priData = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        srcReq = 4'b0001;
        rst = 1'b1;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b0, 1'b1, 4'b0000, 32'h0})
            $display("[TB] FAIL reset_held: got ack=%b blank=%b gnt=%b data=%h, expected ack=0 blank=1 gnt=0000 data=00000000", priAck, blank, srcGnt, dataToShow);
        else passCount++;
        srcReq = 4'b0000;
        rst = 1'b0;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b0, 1'b1, 4'b0000, 32'h0})
            $display("[TB] FAIL reset_idle: got ack=%b blank=%b gnt=%b data=%h, expected ack=0 blank=1 gnt=0000 data=00000000", priAck, blank, srcGnt, dataToShow);
        else passCount++;
    endtask

`ifdef DISP_ARB_AUTO_CYCLE_EN
    task automatic test_auto_cycle();
        int expIdx;
        doReset();
        srcReq = 4'b0001;
        tick();
        checkCount++;
        if ({blank, srcGnt, dataToShow} !== {1'b0, 4'b0001, 32'h11111111})
            $display("[TB] FAIL auto_enter: got blank=%b gnt=%b data=%h, expected blank=0 gnt=0001 data=11111111", blank, srcGnt, dataToShow);
        else passCount++;
        srcReq = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            expIdx = (k >= 4 && k < 8) ? 2 : 0;
            checkCount++;
            if ({srcGnt, dataToShow} !== {4'b0001 << expIdx, srcData[expIdx*32 +: 32]})
                $display("[TB] FAIL auto_dwell_%0d: got gnt=%b data=%h, expected gnt=%b data=%h", k, srcGnt, dataToShow, 4'b0001 << expIdx, srcData[expIdx*32 +: 32]);
            else passCount++;
        end
        srcReq = 4'b0010;
        tick();
        tick();
        selBtn = 1'b1;
        tick();
        checkCount++;
        if (srcGnt !== 4'b0010)
            $display("[TB] FAIL auto_sole_press: got gnt=%b, expected gnt=0010", srcGnt);
        else passCount++;
        selBtn = 1'b0;
        srcReq = 4'b1010;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkCount++;
            if (srcGnt !== ((k < 4) ? 4'b0010 : 4'b1000))
                $display("[TB] FAIL auto_restart_%0d: got gnt=%b, expected gnt=%b", k, srcGnt, (k < 4) ? 4'b0010 : 4'b1000);
            else passCount++;
        end
    endtask
`else
    task automatic test_manual_step();
        int expIdx;
        doReset();
        srcReq = 4'b0001;
        tick();
        checkCount++;
        if ({blank, srcGnt, dataToShow} !== {1'b0, 4'b0001, 32'h11111111})
            $display("[TB] FAIL manual_enter: got blank=%b gnt=%b data=%h, expected blank=0 gnt=0001 data=11111111", blank, srcGnt, dataToShow);
        else passCount++;
        srcReq = 4'b1111;
        repeat (20) tick();
        checkCount++;
        if ({srcGnt, dataToShow} !== {4'b0001, 32'h11111111})
            $display("[TB] FAIL manual_no_rotate: got gnt=%b data=%h, expected gnt=0001 data=11111111", srcGnt, dataToShow);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            expIdx = (i + 1) % 4;
            selBtn = 1'b1;
            tick();
            checkCount++;
            if ({srcGnt, dataToShow} !== {4'b0001 << expIdx, srcData[expIdx*32 +: 32]})
                $display("[TB] FAIL manual_step_%0d: got gnt=%b data=%h, expected gnt=%b data=%h", i, srcGnt, dataToShow, 4'b0001 << expIdx, srcData[expIdx*32 +: 32]);
            else passCount++;
            tick();
            selBtn = 1'b0;
            tick();
            checkCount++;
            if (srcGnt !== (4'b0001 << expIdx))
                $display("[TB] FAIL manual_level_%0d: got gnt=%b, expected gnt=%b", i, srcGnt, 4'b0001 << expIdx);
            else passCount++;
        end
    endtask
`endif

    task automatic test_live_data();
        doReset();
        srcReq = 4'b0001;
        tick();
        srcData[31:0] = 32'hA5A50F0F;
        tick();
        checkCount++;
        if (dataToShow !== 32'hA5A50F0F)
            $display("[TB] FAIL live_data_a: got data=%h, expected data=a5a50f0f", dataToShow);
        else passCount++;
        srcData[31:0] = 32'h01234567;
        tick();
        checkCount++;
        if (dataToShow !== 32'h01234567)
            $display("[TB] FAIL live_data_b: got data=%h, expected data=01234567", dataToShow);
        else passCount++;
        srcData[31:0] = 32'h11111111;
        tick();
    endtask

    task automatic test_request_drop();
        doReset();
        srcReq = 4'b0001;
        tick();
        srcReq = 4'b0010;
        tick();
        checkCount++;
        if ({blank, srcGnt, dataToShow} !== {1'b0, 4'b0010, 32'h22222222})
            $display("[TB] FAIL drop_advance: got blank=%b gnt=%b data=%h, expected blank=0 gnt=0010 data=22222222", blank, srcGnt, dataToShow);
        else passCount++;
        srcReq = 4'b0000;
        tick();
        checkCount++;
        if ({blank, srcGnt, dataToShow} !== {1'b1, 4'b0000, 32'h0})
            $display("[TB] FAIL drop_idle: got blank=%b gnt=%b data=%h, expected blank=1 gnt=0000 data=00000000", blank, srcGnt, dataToShow);
        else passCount++;
    endtask

    task automatic test_priority();
        doReset();
        srcReq = 4'b0001;
        tick();
        priReq = 1'b1;
        priData = 32'hDEADBEEF;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b1, 1'b0, 4'b0000, 32'hDEADBEEF})
            $display("[TB] FAIL pri_capture: got ack=%b blank=%b gnt=%b data=%h, expected ack=1 blank=0 gnt=0000 data=deadbeef", priAck, blank, srcGnt, dataToShow);
        else passCount++;
        priReq = 1'b0;
        priData = 32'h12345678;
        selBtn = 1'b1;
        tick();
        checkCount++;
        if ({priAck, srcGnt, dataToShow} !== {1'b0, 4'b0000, 32'hDEADBEEF})
            $display("[TB] FAIL pri_hold_1: got ack=%b gnt=%b data=%h, expected ack=0 gnt=0000 data=deadbeef", priAck, srcGnt, dataToShow);
        else passCount++;
        selBtn = 1'b0;
        tick();
        checkCount++;
        if ({priAck, srcGnt, dataToShow} !== {1'b0, 4'b0000, 32'hDEADBEEF})
            $display("[TB] FAIL pri_hold_2: got ack=%b gnt=%b data=%h, expected ack=0 gnt=0000 data=deadbeef", priAck, srcGnt, dataToShow);
        else passCount++;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b0, 1'b0, 4'b0001, 32'h11111111})
            $display("[TB] FAIL pri_resume: got ack=%b blank=%b gnt=%b data=%h, expected ack=0 blank=0 gnt=0001 data=11111111", priAck, blank, srcGnt, dataToShow);
        else passCount++;
        srcReq = 4'b0000;
        priReq = 1'b1;
        priData = 32'h0BADF00D;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b1, 1'b0, 4'b0000, 32'h0BADF00D})
            $display("[TB] FAIL pri_beats_drop: got ack=%b blank=%b gnt=%b data=%h, expected ack=1 blank=0 gnt=0000 data=0badf00d", priAck, blank, srcGnt, dataToShow);
        else passCount++;
        priReq = 1'b0;
        tick();
        tick();
        checkCount++;
        if ({blank, dataToShow} !== {1'b0, 32'h0BADF00D})
            $display("[TB] FAIL pri_hold_end: got blank=%b data=%h, expected blank=0 data=0badf00d", blank, dataToShow);
        else passCount++;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b0, 1'b1, 4'b0000, 32'h0})
            $display("[TB] FAIL pri_to_idle: got ack=%b blank=%b gnt=%b data=%h, expected ack=0 blank=1 gnt=0000 data=00000000", priAck, blank, srcGnt, dataToShow);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] expData;
        logic        expAck;
        doReset();
        srcReq = 4'b0001;
        tick();
        for (int t = 0; t < 8; t++) begin
            priReq = 1'b1;
            priData = 32'h100 + 32'(t);
            tick();
            expData = 32'h100 + 32'((t / 3) * 3);
            expAck = (t % 3 == 0);
            checkCount++;
            if ({priAck, srcGnt, dataToShow} !== {expAck, 4'b0000, expData})
                $display("[TB] FAIL recapture_%0d: got ack=%b gnt=%b data=%h, expected ack=%b gnt=0000 data=%h", t, priAck, srcGnt, dataToShow, expAck, expData);
            else passCount++;
        end
        priReq = 1'b0;
        tick();
        checkCount++;
        if ({priAck, dataToShow} !== {1'b0, 32'h106})
            $display("[TB] FAIL recapture_tail: got ack=%b data=%h, expected ack=0 data=00000106", priAck, dataToShow);
        else passCount++;
        tick();
        checkCount++;
        if ({srcGnt, dataToShow} !== {4'b0001, 32'h11111111})
            $display("[TB] FAIL recapture_resume: got gnt=%b data=%h, expected gnt=0001 data=11111111", srcGnt, dataToShow);
        else passCount++;
    endtask

    task automatic test_rst_midhold();
        doReset();
        priReq = 1'b1;
        priData = 32'hCAFEF00D;
        tick();
        checkCount++;
        if ({priAck, dataToShow} !== {1'b1, 32'hCAFEF00D})
            $display("[TB] FAIL rst_setup: got ack=%b data=%h, expected ack=1 data=cafef00d", priAck, dataToShow);
        else passCount++;
        priReq = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b0, 1'b1, 4'b0000, 32'h0})
            $display("[TB] FAIL rst_async: got ack=%b blank=%b gnt=%b data=%h, expected ack=0 blank=1 gnt=0000 data=00000000", priAck, blank, srcGnt, dataToShow);
        else passCount++;
        tick();
        rst = 1'b0;
        tick();
        checkCount++;
        if ({priAck, blank, srcGnt, dataToShow} !== {1'b0, 1'b1, 4'b0000, 32'h0})
            $display("[TB] FAIL rst_after: got ack=%b blank=%b gnt=%b data=%h, expected ack=0 blank=1 gnt=0000 data=00000000", priAck, blank, srcGnt, dataToShow);
        else passCount++;
    endtask

    initial begin
        tick();
        test_reset();
`ifdef DISP_ARB_AUTO_CYCLE_EN
        test_auto_cycle();
`else
        test_manual_step();
`endif
        test_live_data();
        test_request_drop();
        test_priority();
        test_back_to_back();
        test_rst_midhold();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
